iter_shifter: RTL and testbench

ITER_SHIFTER -- requirements
Module: iter_shifter

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_step.sv | 38 +++
 rtl/iter_shifter.sv | 96 +++++++++
 tb/tb_iter_shifter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the iterative shifter: operation encodings and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP bit positions.
// Rotate logic only exists when ITER_SHIFTER_ROTATE_EN is defined; otherwise ROL acts as SLL.
module shift_step
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int AW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    amt,
  input  shift_op_e        op,
  output logic [WIDTH-1:0] data_out
);

`ifdef ITER_SHIFTER_ROTATE_EN
  // Shifting the doubled word left leaves the rotated result in the upper half.
  logic [2*WIDTH-1:0] rot;
  assign rot = {data_in, data_in} << amt;
`endif

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case can leave it unassigned and infer a latch.
    data_out = data_in;
    unique case (op)
      OP_SLL: data_out = data_in << amt;
      OP_SRL: data_out = data_in >> amt;
      OP_SRA: data_out = $signed(data_in) >>> amt;
`ifdef ITER_SHIFTER_ROTATE_EN
      OP_ROL: data_out = rot[2*WIDTH-1:WIDTH];
`else
      OP_ROL: data_out = data_in << amt;
`endif
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: shifts at most STEP positions per clock until done.
// Optional rotate support is enabled with the ITER_SHIFTER_ROTATE_EN macro.
module iter_shifter
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int             AW     = $clog2(STEP + 1);
  localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  shift_op_e        op_q, op_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [SHW-1:0]   step_amt;
  logic [WIDTH-1:0] step_out;

  assign step_amt = (rem_q > STEP_W) ? STEP_W : rem_q;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data_in  (work_q),
    .amt      (step_amt[AW-1:0]),
    .op       (op_q),
    .data_out (step_out)
  );

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      // NOTE: the working register is reset too, because out_data is
      // required to read zero after reset, not whatever was left behind.
      work_q  <= '0;
      op_q    <= OP_SLL;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          op_d    = shift_op_e'(in_op);
          rem_d   = in_shamt;
          state_d = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d = step_out;
        rem_d  = rem_q - step_amt;
        if (rem_q == step_amt) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    out_data  = work_q;
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter (WIDTH=32, STEP=4); tracks ITER_SHIFTER_ROTATE_EN.
module tb_iter_shifter;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  iter_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: a single-cycle shift computed directly from the operation rules.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'b00: r = d << s;
      2'b01: r = d >> s;
      2'b10: r = $signed(d) >>> s;
      default: begin
`ifdef ITER_SHIFTER_ROTATE_EN
        r = (s == 0) ? d : ((d << s) | (d >> (32 - s)));
`else
        r = d << s;
`endif
      end
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request, check latency, hold behaviour under stalls, and release.
  task automatic do_req(input logic [31:0] d, input int s, input logic [1:0] op,
                        input int stalls, input logic [31:0] exp, input string tag);
    int lat;
    check({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s[4:0];
    in_op    = op;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    in_shamt = 5'($urandom);
    in_op    = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      check({tag, "_busy"}, {busy, in_ready}, 2'b10);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_latency"}, lat, (s + STEP - 1) / STEP);
    check({tag, "_data"}, out_data, exp);
    for (int k = 0; k < stalls; k++) begin
      in_valid = 1'($urandom);
      tick();
      check({tag, "_hold"}, {out_valid, in_ready, busy, out_data}, {3'b101, exp});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_release"}, {out_valid, busy, in_ready}, 3'b001);
  endtask

  initial begin
    logic [31:0] d;
    int          s;
    logic [1:0]  op;
    int          stalls;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check("reset_state", {out_valid, busy, in_ready, out_data}, {3'b001, 32'h0});
    rst_n = 1'b1;
    tick();

    do_req(32'h0000_0001, 5,  2'b00, 0, 32'h0000_0020, "sll_5");
    do_req(32'h8000_0000, 31, 2'b10, 1, 32'hFFFF_FFFF, "sra_31");
    do_req(32'h8000_0000, 31, 2'b01, 0, 32'h0000_0001, "srl_31");
    do_req(32'h1234_5678, 0,  2'b00, 2, 32'h1234_5678, "sll_0");
`ifdef ITER_SHIFTER_ROTATE_EN
    do_req(32'h8000_0001, 4,  2'b11, 5, 32'h0000_0018, "rol_4");
`else
    do_req(32'h8000_0001, 4,  2'b11, 5, 32'h0000_0010, "rol_4");
`endif
    do_req(32'h8000_0000, 31, 2'b11, 0, ref_shift(32'h8000_0000, 31, 2'b11), "rol_31");

    // Reset on the 2nd edge after accept of a long shift discards the operation.
    in_valid = 1'b1;
    in_data  = 32'hFFFF_0000;
    in_shamt = 5'd16;
    in_op    = 2'b01;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_shift", {out_valid, busy, in_ready, out_data}, {3'b001, 32'h0});
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rst_shift_quiet", {out_valid, busy}, 2'b00);
    end

    // Reset while a result waits in DONE also drops it.
    in_valid = 1'b1;
    in_data  = 32'hA5A5_A5A5;
    in_shamt = 5'd0;
    in_op    = 2'b00;
    tick();
    in_valid = 1'b0;
    check("done_before_rst", out_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_done", {out_valid, busy, in_ready, out_data}, {3'b001, 32'h0});

    for (int i = 0; i < 3000; i++) begin
      d      = $urandom;
      s      = $urandom_range(0, 31);
      op     = 2'($urandom_range(0, 3));
      stalls = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      do_req(d, s, op, stalls, ref_shift(d, s, op), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
